// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, start/done handshake, busy while RUN/DONE.
// Optional signed mode is compiled in with SEQ_DIV_SIGNED_EN (adds the signed_op port).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic dvd_neg, dsr_neg;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    // Divide magnitudes; signs are reapplied on the way into DONE.
    always_comb begin
        dvd_neg = signed_op & dividend[WIDTH-1];
        dsr_neg = signed_op & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? negate(dividend) : dividend;
        dsr_mag = dsr_neg ? negate(divisor) : divisor;
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dsr_mag = divisor;
    end
`endif

    // One restoring step; the extra top bit keeps the shifted-out remainder bit.
    always_comb begin
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        q_bit  = ~diff[WIDTH];
        rem_nx = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {dvd_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = dvd_mag;
                        dsr_d   = dsr_mag;
`ifdef SEQ_DIV_SIGNED_EN
                        qneg_d  = dvd_neg ^ dsr_neg;
                        rneg_d  = dvd_neg;
`endif
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_nx;
                dvd_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
`ifdef SEQ_DIV_SIGNED_EN
                    quo_d   = qneg_q ? negate(quo_nx) : quo_nx;
                    rmd_d   = rneg_q ? negate(rem_nx) : rem_nx;
`else
                    quo_d   = quo_nx;
                    rmd_d   = rem_nx;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a negedge monitor pops on done.
module tb_seq_divider;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         signed_op;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        e.dbz = 1'b0;
        e.cyc = 0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (s) begin
            if (a == MIN && b == '1) begin
                e.q = MIN;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 64'(quotient), 64'(e.q));
                chk("remainder", 64'(remainder), 64'(e.r));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", 64'(busy), 64'd1);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        e     = model(a, b, s);
        e.cyc = cyc + ((b == '0) ? 0 : W);
        sb.push_back(e);
        chk("busy_after_start", 64'(busy), 64'd1);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 4 * W) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL done_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        issue(a, b, s);
        wait_idle();
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        reset     = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        signed_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_q", 64'(quotient), 64'd0);
        chk("reset_r", 64'(remainder), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run(32'd100, 32'd7, 1'b0);
        run(32'hFFFF_FFFF, 32'd1, 1'b0);
        run(32'hFFFF_FFFF, 32'h0001_0000, 1'b0);
        run(32'd5, 32'd0, 1'b0);
        run(32'd9, 32'd3, 1'b0);
        run(32'd3, 32'd9, 1'b0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // A start pulse while busy must be ignored entirely.
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        dividend = 32'd8;
        divisor  = 32'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // Reset mid-operation discards the result; monitor flags any later done.
        issue(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_q", 64'(quotient), 64'd0);
        chk("midreset_r", 64'(remainder), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 5) @(negedge clk);
        chk("post_reset_idle", 64'(busy), 64'd0);
        run(32'd20, 32'd6, 1'b0);

`ifdef SEQ_DIV_SIGNED_EN
        run(32'hFFFF_FFF9, 32'd2, 1'b1);
        run(32'd7, 32'hFFFF_FFFE, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
        run(32'hFFFF_FFF9, 32'd0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom_range(1, 255);
                1:       b = '0;
                2:       b = a + W'($urandom_range(1, 1000));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
`ifdef SEQ_DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run(a, b, s);
        end

        repeat (5) @(negedge clk);
        chk("final_idle", 64'(busy), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
